l2_cache_control: RTL and testbench

Control FSM for the 4-way, 16-bit-address L2 cache. It sits between the I/D arbiter and physical memory and sequences hit, write-back and fill. It drives `write_back_bit` into the pmem address calculator, which selects the victim tag (writeback) or the arbiter address (fill). It owns victim selection and pseudo-LRU update, and its victim decode matches the address calculator's tag selection exactly.

---
 rtl/l2_cache_control_pkg.sv | 53 +++++
 rtl/l2_cache_control_plru_policy.sv | 18 +
 rtl/l2_cache_control.sv | 135 +++++++++++++
 tb/tb_l2_cache_control.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_control_pkg.sv
// rtl/l2_cache_control_pkg.sv - shared types and PLRU helpers for the L2 cache control FSM
//   state_t     : controller states
//   plru_t      : 3-bit tree PLRU ([0] root, [1] ways 0/1, [2] ways 2/3; bits point at the victim)
//   way_oh_t    : one-hot way vector
//   plru_victim : PLRU bits -> victim way index
//   plru_update : PLRU bits + accessed way -> new PLRU bits
//   way_onehot  : way index -> one-hot
//   way_index   : one-hot (or multi-hot) -> lowest set way index
package l2_types;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_COMPARE    = 2'd1,
        ST_WRITE_BACK = 2'd2,
        ST_FETCH      = 2'd3
    } state_t;

    typedef logic [2:0] plru_t;
    typedef logic [3:0] way_oh_t;

    // Must match the tag select in the pmem address calculator exactly.
    function automatic logic [1:0] plru_victim(input plru_t lru);
        if (!lru[0]) begin
            return lru[1] ? 2'd1 : 2'd0;
        end
        return lru[2] ? 2'd3 : 2'd2;
    endfunction

    // Point the tree away from the accessed way; the bit of the other pair is untouched.
    function automatic plru_t plru_update(input plru_t lru, input logic [1:0] way);
        plru_t n;
        n = lru;
        case (way)
            2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
            2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
            2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
            default: begin n[0] = 1'b0; n[2] = 1'b0; end
        endcase
        return n;
    endfunction

    function automatic way_oh_t way_onehot(input logic [1:0] way);
        return way_oh_t'(4'b0001 << way);
    endfunction

    function automatic logic [1:0] way_index(input way_oh_t oh);
        if (oh[0]) return 2'd0;
        if (oh[1]) return 2'd1;
        if (oh[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/l2_cache_control_plru_policy.sv
// rtl/l2_cache_control_plru_policy.sv - combinational PLRU victim decode and update
//   lru_in     in  3 : PLRU bits of the indexed set
//   access_way in  2 : way being accessed (hit way)
//   victim     out 2 : PLRU victim way index
//   lru_new    out 3 : PLRU bits after the access
module l2_plru_policy
    import l2_types::*;
(
    input  plru_t      lru_in,
    input  logic [1:0] access_way,
    output logic [1:0] victim,
    output plru_t      lru_new
);

    assign victim  = plru_victim(lru_in);
    assign lru_new = plru_update(lru_in, access_way);

endmodule

// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - L2 cache control FSM: hit, write-back and fill sequencing
//   clk, rst (sync, active-high)
//   arb_read/arb_write in, arb_resp out       : arbiter request/response
//   hit_way, valid, dirty in 4, LRU_out in 3  : indexed-set status
//   pmem_resp in, pmem_read/pmem_write out    : physical memory handshake
//   write_back_bit out                        : victim-tag address select for writeback
//   way_load out 4, data_sel, set_dirty, clr_dirty out : array update controls
//   lru_load out, lru_new out 3               : PLRU write
//   Optional: L2_FILL_INVALID_FIRST_EN - fill the lowest invalid way before using PLRU.
module l2_cache_control
    import l2_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_read,
    input  logic       arb_write,
    output logic       arb_resp,
    input  logic [3:0] hit_way,
    input  logic [3:0] valid,
    input  logic [3:0] dirty,
    input  logic [2:0] LRU_out,
    input  logic       pmem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    output logic       write_back_bit,
    output logic [3:0] way_load,
    output logic       data_sel,
    output logic       set_dirty,
    output logic       clr_dirty,
    output logic       lru_load,
    output logic [2:0] lru_new
);

    state_t     state;
    state_t     state_next;
    logic [1:0] victim;
    logic [1:0] plru_way;
    logic [1:0] miss_victim;
    logic       victim_dirty;
    plru_t      lru_upd;
    logic       req;
    logic       is_hit;
    logic       is_miss;

    assign req     = arb_read | arb_write;
    assign is_hit  = |hit_way;
    assign is_miss = (state == ST_COMPARE) && req && !is_hit;

    l2_plru_policy u_plru (
        .lru_in     (LRU_out),
        .access_way (way_index(hit_way)),
        .victim     (plru_way),
        .lru_new    (lru_upd)
    );

    // Only a valid dirty line needs writing back; writeback is always on the
    // PLRU victim, which is what the address calculator decodes.
`ifdef L2_FILL_INVALID_FIRST_EN
    logic any_invalid;
    assign any_invalid  = ~&valid;
    assign miss_victim  = any_invalid ? way_index(~valid) : plru_way;
    assign victim_dirty = any_invalid ? 1'b0 : (dirty[plru_way] & valid[plru_way]);
`else
    assign miss_victim  = plru_way;
    assign victim_dirty = dirty[plru_way] & valid[plru_way];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            victim <= 2'd0;
        end else begin
            state <= state_next;
            if (is_miss) begin
                victim <= miss_victim;
            end
        end
    end

    always_comb begin
        state_next     = state;
        arb_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        write_back_bit = 1'b0;
        way_load       = 4'b0000;
        data_sel       = 1'b0;
        set_dirty      = 1'b0;
        clr_dirty      = 1'b0;
        lru_load       = 1'b0;
        lru_new        = 3'b000;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (is_hit) begin
                    arb_resp   = 1'b1;
                    lru_load   = 1'b1;
                    lru_new    = lru_upd;
                    // Read+write together is handled as a write.
                    if (arb_write) begin
                        way_load  = hit_way;
                        set_dirty = 1'b1;
                    end
                    state_next = ST_IDLE;
                end else begin
                    state_next = victim_dirty ? ST_WRITE_BACK : ST_FETCH;
                end
            end
            ST_WRITE_BACK: begin
                write_back_bit = 1'b1;
                pmem_write     = 1'b1;
                if (pmem_resp) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    way_load   = way_onehot(victim);
                    data_sel   = 1'b1;
                    clr_dirty  = 1'b1;
                    state_next = ST_COMPARE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_cache_control.sv
// tb/tb_l2_cache_control.sv - directed self-checking bench for l2_cache_control
module tb_l2_cache_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       arb_read;
    logic       arb_write;
    logic       arb_resp;
    logic [3:0] hit_way;
    logic [3:0] valid;
    logic [3:0] dirty;
    logic [2:0] LRU_out;
    logic       pmem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       write_back_bit;
    logic [3:0] way_load;
    logic       data_sel;
    logic       set_dirty;
    logic       clr_dirty;
    logic       lru_load;
    logic [2:0] lru_new;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_cache_control dut (
        .clk            (clk),
        .rst            (rst),
        .arb_read       (arb_read),
        .arb_write      (arb_write),
        .arb_resp       (arb_resp),
        .hit_way        (hit_way),
        .valid          (valid),
        .dirty          (dirty),
        .LRU_out        (LRU_out),
        .pmem_resp      (pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .write_back_bit (write_back_bit),
        .way_load       (way_load),
        .data_sel       (data_sel),
        .set_dirty      (set_dirty),
        .clr_dirty      (clr_dirty),
        .lru_load       (lru_load),
        .lru_new        (lru_new)
    );

    // {arb_resp, pmem_read, pmem_write, write_back_bit, way_load, data_sel, set_dirty, clr_dirty, lru_load, lru_new}
    logic [14:0] outs;
    assign outs = {arb_resp, pmem_read, pmem_write, write_back_bit, way_load,
                   data_sel, set_dirty, clr_dirty, lru_load, lru_new};

    localparam logic [14:0] ZERO = 15'd0;
    localparam logic [14:0] PRD  = 15'b010_0000_0000_0000;
    localparam logic [14:0] PWB  = 15'b001_1000_0000_0000;

    function automatic logic [14:0] hit_exp(input logic [3:0] wl, input logic sd, input logic [2:0] ln);
        return {1'b1, 3'b000, wl, 1'b0, sd, 1'b0, 1'b1, ln};
    endfunction

    function automatic logic [14:0] fill_exp(input logic [3:0] wl);
        return {1'b0, 1'b1, 2'b00, wl, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [14:0] exp);
        #1;
        n_checks++;
        assert (outs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    logic [3:0] fill_way;
    logic [2:0] fill_lru;

    initial begin
        rst = 1'b1; arb_read = 1'b0; arb_write = 1'b0; hit_way = 4'b0000;
        valid = 4'b1111; dirty = 4'b0000; LRU_out = 3'b000; pmem_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_idle", ZERO);

        // Read hit, way 2
        arb_read = 1'b1; hit_way = 4'b0100; LRU_out = 3'b000;
        check("rd_hit_idle", ZERO);
        tick();
        check("rd_hit_resp", hit_exp(4'b0000, 1'b0, 3'b100));
        arb_read = 1'b0; hit_way = 4'b0000;
        tick();
        check("rd_hit_back_idle", ZERO);

        // Write hit, way 1
        arb_write = 1'b1; hit_way = 4'b0010; LRU_out = 3'b000;
        tick();
        check("wr_hit_resp", hit_exp(4'b0010, 1'b1, 3'b001));
        arb_write = 1'b0; hit_way = 4'b0000;
        tick();

        // Read and write together behave as a write; way 0 from 111
        arb_read = 1'b1; arb_write = 1'b1; hit_way = 4'b0001; LRU_out = 3'b111;
        tick();
        check("rdwr_hit_resp", hit_exp(4'b0001, 1'b1, 3'b111));
        arb_read = 1'b0; arb_write = 1'b0; hit_way = 4'b0000;
        tick();

        // pmem_resp in IDLE is ignored
        pmem_resp = 1'b1;
        check("idle_pmem_resp", ZERO);
        tick();
        check("idle_pmem_resp_stay", ZERO);
        pmem_resp = 1'b0;

        // Clean miss: PLRU 101 -> way 3
        arb_read = 1'b1; LRU_out = 3'b101; dirty = 4'b0000; valid = 4'b1111;
        tick();
        check("clean_cmp_miss", ZERO);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clean_fetch_wait%0d", i), PRD);
            tick();
        end
        pmem_resp = 1'b1;
        check("clean_fill", fill_exp(4'b1000));
        tick();
        pmem_resp = 1'b0; hit_way = 4'b1000;
        check("clean_rehit", hit_exp(4'b0000, 1'b0, 3'b000));
        arb_read = 1'b0; hit_way = 4'b0000;
        tick();
        check("clean_back_idle", ZERO);

        // Dirty miss: PLRU 010 -> way 1, dirty
        arb_write = 1'b1; LRU_out = 3'b010; dirty = 4'b0010;
        tick();
        check("dirty_cmp_miss", ZERO);
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dirty_wb_wait%0d", i), PWB);
            tick();
        end
        pmem_resp = 1'b1;
        check("dirty_wb_resp", PWB);
        tick();
        pmem_resp = 1'b0;
        check("dirty_fetch_wait", PRD);
        tick();
        pmem_resp = 1'b1;
        check("dirty_fill", fill_exp(4'b0010));
        tick();
        pmem_resp = 1'b0; hit_way = 4'b0010; dirty = 4'b0000;
        check("dirty_rehit", hit_exp(4'b0010, 1'b1, 3'b001));
        arb_write = 1'b0; hit_way = 4'b0000;
        tick();
        check("dirty_back_idle", ZERO);

        // Request dropped during COMPARE miss
        arb_read = 1'b1; LRU_out = 3'b000;
        tick();
        arb_read = 1'b0;
        check("drop_cmp", ZERO);
        tick();
        check("drop_idle", ZERO);
        tick();
        check("drop_still_idle", ZERO);

        // Reset during WRITE_BACK
        arb_read = 1'b1; LRU_out = 3'b010; dirty = 4'b0010;
        tick(); tick();
        check("rst_wb_active", PWB);
        rst = 1'b1;
        tick();
        rst = 1'b0; arb_read = 1'b0;
        check("rst_wb_cleared", ZERO);
        tick();
        check("rst_wb_idle", ZERO);

        // Way 2 invalid, PLRU picks way 1; pmem_resp on FETCH entry is honoured
`ifdef L2_FILL_INVALID_FIRST_EN
        fill_way = 4'b0100; fill_lru = 3'b110;
`else
        fill_way = 4'b0010; fill_lru = 3'b001;
`endif
        arb_read = 1'b1; valid = 4'b1011; dirty = 4'b0000; LRU_out = 3'b010;
        tick();
        check("inv_cmp_miss", ZERO);
        tick();
        pmem_resp = 1'b1;
        check("inv_fill", fill_exp(fill_way));
        tick();
        pmem_resp = 1'b0; hit_way = fill_way; valid = 4'b1111;
        check("inv_rehit", hit_exp(4'b0000, 1'b0, fill_lru));
        arb_read = 1'b0; hit_way = 4'b0000;
        tick();
        check("inv_back_idle", ZERO);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
